// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream header arbiter slice.
//   axis_state_e : arbiter FSM encoding (IDLE / HDR / DATA)
// -----------------------------------------------------------------------------
package axis_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } axis_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req starting at last_grant+1
// (modulo N_REQ) and returns the first requester found.
// Ports:
//   req        : request vector, one bit per requester
//   last_grant : index of the most recently served requester
//   grant      : winning index (0 when no request is present)
//   any_req    : high when at least one request bit is set
// -----------------------------------------------------------------------------
module rr_arbiter
   import axis_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [IDX_W-1:0] grant,
   output logic             any_req
);

   logic [IDX_W-1:0] idx;

   // Walk the ring from farthest to nearest so the nearest hit is the last
   // assignment and therefore the winner.
   always_comb begin
      grant   = '0;
      idx     = '0;
      any_req = |req;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = IDX_W'((int'(last_grant) + k) % N_REQ);
         if (req[idx]) begin
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// -----------------------------------------------------------------------------
// axi_stream_header_arbiter
// Round-robin arbiter granting one of N_REQ requesters the header channel and
// then the data channel for a whole packet. Only the FSM state, grant_idx and
// last_grant are registered; the mux path is purely combinational.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge where
// valid and ready are both high. Valid never depends on ready; the arbiter
// forwards the granted requester's valid downstream and the downstream ready
// back to the granted requester only, all other readies stay 0.
//
// Ports:
//   clk, rst_n                                 : clock, async active-low reset
//   s_valid_insert/s_ready_insert              : per-requester header handshake
//   s_header_insert/s_keep_insert              : packed headers / header keeps
//   s_valid_in/s_ready_in/s_last_in            : per-requester data handshake
//   s_data_in/s_keep_in                        : packed data / data keeps
//   m_valid_insert/m_header_insert/m_keep_insert, m_ready_insert : header out
//   m_valid_in/m_data_in/m_keep_in/m_last_in, m_ready_in         : data out
//   grant_idx                                  : current owner
//   busy                                       : high in HDR or DATA
//   state_dbg                                  : FSM state for observation
// -----------------------------------------------------------------------------
module axi_stream_header_arbiter
   import axis_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int N_REQ        = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_REQ-1:0]                s_valid_insert,
   output logic [N_REQ-1:0]                s_ready_insert,
   input  logic [N_REQ*DATA_WD-1:0]        s_header_insert,
   input  logic [N_REQ*DATA_BYTE_WD-1:0]   s_keep_insert,
   input  logic [N_REQ-1:0]                s_valid_in,
   output logic [N_REQ-1:0]                s_ready_in,
   input  logic [N_REQ-1:0]                s_last_in,
   input  logic [N_REQ*DATA_WD-1:0]        s_data_in,
   input  logic [N_REQ*DATA_BYTE_WD-1:0]   s_keep_in,
   output logic                            m_valid_insert,
   output logic [DATA_WD-1:0]              m_header_insert,
   output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
   input  logic                            m_ready_insert,
   output logic                            m_valid_in,
   output logic [DATA_WD-1:0]              m_data_in,
   output logic [DATA_BYTE_WD-1:0]         m_keep_in,
   output logic                            m_last_in,
   input  logic                            m_ready_in,
   output logic [$clog2(N_REQ)-1:0]        grant_idx,
   output logic                            busy,
   output axis_state_e                     state_dbg
);

   localparam int IDX_W = $clog2(N_REQ);

   axis_state_e      state, state_nxt;
   logic [IDX_W-1:0] grant_nxt;
   logic [IDX_W-1:0] last_grant, last_grant_nxt;
   logic [IDX_W-1:0] arb_grant;
   logic             arb_any;

   // Only headers compete; a requester with data but no header never wins.
   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (s_valid_insert),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (arb_any)
   );

   // Reset value of last_grant makes requester 0 the first one searched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant_idx  <= '0;
         last_grant <= IDX_W'(N_REQ - 1);
      end else begin
         state      <= state_nxt;
         grant_idx  <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_idx;
      last_grant_nxt = last_grant;
      s_ready_insert = '0;
      s_ready_in     = '0;
      m_valid_insert = 1'b0;
      m_valid_in     = 1'b0;
      // Payload fields follow the owner at all times; valids qualify them.
      m_header_insert = s_header_insert[grant_idx*DATA_WD +: DATA_WD];
      m_keep_insert   = s_keep_insert[grant_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
      m_data_in       = s_data_in[grant_idx*DATA_WD +: DATA_WD];
      m_keep_in       = s_keep_in[grant_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
      m_last_in       = s_last_in[grant_idx];

      case (state)
         IDLE: begin
            if (arb_any) begin
               grant_nxt = arb_grant;
               state_nxt = HDR;
            end
         end
         HDR: begin
            m_valid_insert            = s_valid_insert[grant_idx];
            s_ready_insert[grant_idx] = m_ready_insert;
            if (m_valid_insert && m_ready_insert) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            m_valid_in            = s_valid_in[grant_idx];
            s_ready_in[grant_idx] = m_ready_in;
            if (m_valid_in && m_ready_in && m_last_in) begin
               state_nxt      = IDLE;
               last_grant_nxt = grant_idx;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_header_arbiter
// Directed bench: a per-requester source model drives packets, the test
// sequence pushes the expected header/data stream (in hand-derived grant
// order) into queues, and a monitor pops and compares on every downstream
// handshake. Cycle-exact checks cover grants, bubbles and readies.
// -----------------------------------------------------------------------------
module tb_axi_stream_header_arbiter;
   import axis_pkg::*;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam int NR = 4;
   localparam int IW = 2;
   localparam int HW = IW + KW + DW;
   localparam int BW = IW + KW + DW + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [NR-1:0]    s_valid_insert, s_ready_insert;
   logic [NR*DW-1:0] s_header_insert;
   logic [NR*KW-1:0] s_keep_insert;
   logic [NR-1:0]    s_valid_in, s_ready_in, s_last_in;
   logic [NR*DW-1:0] s_data_in;
   logic [NR*KW-1:0] s_keep_in;
   logic             m_valid_insert, m_ready_insert;
   logic [DW-1:0]    m_header_insert;
   logic [KW-1:0]    m_keep_insert;
   logic             m_valid_in, m_ready_in, m_last_in;
   logic [DW-1:0]    m_data_in;
   logic [KW-1:0]    m_keep_in;
   logic [IW-1:0]    grant_idx;
   logic             busy;
   axis_state_e      state_dbg;

   axi_stream_header_arbiter #(
      .DATA_WD (DW), .DATA_BYTE_WD (KW), .N_REQ (NR)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .s_valid_insert (s_valid_insert), .s_ready_insert (s_ready_insert),
      .s_header_insert (s_header_insert), .s_keep_insert (s_keep_insert),
      .s_valid_in (s_valid_in), .s_ready_in (s_ready_in), .s_last_in (s_last_in),
      .s_data_in (s_data_in), .s_keep_in (s_keep_in),
      .m_valid_insert (m_valid_insert), .m_header_insert (m_header_insert),
      .m_keep_insert (m_keep_insert), .m_ready_insert (m_ready_insert),
      .m_valid_in (m_valid_in), .m_data_in (m_data_in), .m_keep_in (m_keep_in),
      .m_last_in (m_last_in), .m_ready_in (m_ready_in),
      .grant_idx (grant_idx), .busy (busy), .state_dbg (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [HW-1:0] exp_h_q[$];
   logic [BW-1:0] exp_d_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- source model ----------------
   int            pkts_left[NR], pkt_no[NR], nbeats[NR], beat[NR];
   logic          hdr_pend[NR], dat_act[NR], rogue[NR];
   logic [KW-1:0] keep_last[NR];
   logic [NR-1:0] hs_hdr, hs_dat;
   logic          mr_ins, mr_in;

   function automatic logic [DW-1:0] hdr_word(input int i, input int p);
      return {8'hAA, 8'(i), 8'(p), 8'h00};
   endfunction

   function automatic logic [DW-1:0] data_word(input int i, input int p, input int b);
      return {8'hDD, 8'(i), 8'(p), 8'(b)};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NR; i++) begin
         pkts_left[i] = 0; pkt_no[i] = 0; nbeats[i] = 0; beat[i] = 0;
         hdr_pend[i] = 1'b0; dat_act[i] = 1'b0; rogue[i] = 1'b0;
         keep_last[i] = 4'hF;
      end
      hs_hdr = '0;
      hs_dat = '0;
   endtask

   task automatic load(input int i, input int npkts, input int nb, input logic [KW-1:0] kl);
      pkts_left[i] = npkts; pkt_no[i] = 0; nbeats[i] = nb; beat[i] = 0;
      hdr_pend[i] = 1'b1; dat_act[i] = 1'b0; keep_last[i] = kl;
   endtask

   task automatic expect_pkt(input int i, input int p, input int nb, input logic [KW-1:0] kl);
      exp_h_q.push_back({IW'(i), 4'hF, hdr_word(i, p)});
      for (int b = 0; b < nb; b++) begin
         exp_d_q.push_back({IW'(i), (b == nb - 1) ? kl : 4'hF, data_word(i, p, b), (b == nb - 1)});
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         s_valid_insert[i]           = hdr_pend[i];
         s_header_insert[i*DW +: DW] = hdr_word(i, pkt_no[i]);
         s_keep_insert[i*KW +: KW]   = 4'hF;
         s_valid_in[i]               = dat_act[i] | rogue[i];
         s_data_in[i*DW +: DW]       = data_word(i, pkt_no[i], beat[i]);
         s_last_in[i]                = (beat[i] == nbeats[i] - 1);
         s_keep_in[i*KW +: KW]       = (beat[i] == nbeats[i] - 1) ? keep_last[i] : 4'hF;
      end
      m_ready_insert = mr_ins;
      m_ready_in     = mr_in;
   endtask

   task automatic advance();
      for (int i = 0; i < NR; i++) begin
         if (hs_hdr[i]) begin
            hdr_pend[i] = 1'b0; dat_act[i] = 1'b1; beat[i] = 0;
         end else if (hs_dat[i] && dat_act[i]) begin
            if (beat[i] == nbeats[i] - 1) begin
               dat_act[i] = 1'b0;
               pkts_left[i]--;
               if (pkts_left[i] > 0) begin
                  pkt_no[i]++; beat[i] = 0; hdr_pend[i] = 1'b1;
               end
            end else begin
               beat[i]++;
            end
         end
      end
   endtask

   // One cycle: inputs change on the falling edge, handshakes noted just after.
   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         advance();
         drive();
         #1;
         hs_hdr = s_valid_insert & s_ready_insert;
         hs_dat = s_valid_in & s_ready_in;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int c = 0;
      while ((exp_h_q.size() != 0 || exp_d_q.size() != 0) && c < budget) begin
         run(1);
         c++;
      end
      check(name, exp_h_q.size() + exp_d_q.size(), 0);
      exp_h_q.delete();
      exp_d_q.delete();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_model();
      drive();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [HW-1:0] eh;
      logic [BW-1:0] ed;
      forever begin
         @(negedge clk);
         #2;
         if (m_valid_insert && m_ready_insert) begin
            if (exp_h_q.size() == 0) begin
               check("unexpected_hdr", {grant_idx, m_keep_insert, m_header_insert}, '0);
            end else begin
               eh = exp_h_q.pop_front();
               check("hdr_beat", {grant_idx, m_keep_insert, m_header_insert}, eh);
            end
         end
         if (m_valid_in && m_ready_in) begin
            if (exp_d_q.size() == 0) begin
               check("unexpected_data", {grant_idx, m_keep_in, m_data_in, m_last_in}, '0);
            end else begin
               ed = exp_d_q.pop_front();
               check("data_beat", {grant_idx, m_keep_in, m_data_in, m_last_in}, ed);
            end
         end
         if (!busy) begin
            check("idle_quiet", {m_valid_insert, m_valid_in, s_ready_insert, s_ready_in}, '0);
         end
         check("valid_excl", m_valid_insert & m_valid_in, 0);
         check("non_owner_ready", (s_ready_insert | s_ready_in) & ~(4'b0001 << grant_idx), 0);
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int exp_g[5];
      mr_ins = 1'b1;
      mr_in  = 1'b1;
      clear_model();
      drive();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_grant", grant_idx, 0);
      check("rst_state", state_dbg, IDLE);
      check("rst_valids", {m_valid_insert, m_valid_in, s_ready_insert, s_ready_in}, 0);
      rst_n = 1'b1;

      // Requesters 0 and 2 after reset: 0 first, bubble, then 2.
      load(0, 1, 3, 4'hF); load(2, 1, 1, 4'hF);
      expect_pkt(0, 0, 3, 4'hF); expect_pkt(2, 0, 1, 4'hF);
      run(1); check("t1_idle", busy, 0);
      run(1); check("t1_grant0", grant_idx, 0); check("t1_rdy_ins", s_ready_insert, 4'b0001);
      run(1); check("t1_data", state_dbg, DATA);
      run(2);
      run(1); check("t1_bubble", busy, 0);
      run(1); check("t1_grant2", grant_idx, 2);
      drain("t1_drain", 20);

      // Everyone requesting with 1-beat packets: rotation 0,1,2,3,0.
      pulse_reset();
      load(0, 2, 1, 4'hF); load(1, 1, 1, 4'hF); load(2, 1, 1, 4'hF); load(3, 1, 1, 4'hF);
      expect_pkt(0, 0, 1, 4'hF); expect_pkt(1, 0, 1, 4'hF); expect_pkt(2, 0, 1, 4'hF);
      expect_pkt(3, 0, 1, 4'hF); expect_pkt(0, 1, 1, 4'hF);
      exp_g = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
         run(1); check("t2_bubble", busy, 0);
         run(1); check("t2_grant", grant_idx, exp_g[k]);
         run(1); check("t2_data", state_dbg, DATA);
      end
      drain("t2_drain", 20);

      // Downstream ready toggling during a 4-beat packet from requester 1.
      pulse_reset();
      load(1, 1, 4, 4'hF);
      expect_pkt(1, 0, 4, 4'hF);
      run(1); check("t3_idle", busy, 0);
      run(1); check("t3_grant", grant_idx, 1);
      for (int k = 0; k < 8; k++) begin
         mr_in = (k % 2 == 0);
         run(1);
         check("t3_own_rdy", s_ready_in, mr_in ? 4'b0010 : 4'b0000);
      end
      check("t3_done", busy, 0);
      mr_in = 1'b1;
      drain("t3_drain", 20);

      // Data without a header on requester 1 must never win or be served.
      pulse_reset();
      rogue[1] = 1'b1;
      load(3, 1, 2, 4'hF);
      expect_pkt(3, 0, 2, 4'hF);
      run(1); check("t4_idle", busy, 0);
      run(1); check("t4_grant", grant_idx, 3); check("t4_rdy1", s_ready_in[1], 0);
      for (int k = 0; k < 2; k++) begin
         run(1); check("t4_rdy1", s_ready_in[1], 0);
      end
      rogue[1] = 1'b0;
      drain("t4_drain", 20);

      // Reset mid-DATA of requester 2, then 2 and 0 pending gives 0.
      pulse_reset();
      load(2, 1, 4, 4'hF);
      expect_pkt(2, 0, 4, 4'hF);
      run(1);
      run(1); check("t5_grant2", grant_idx, 2);
      run(2);
      mr_in = 1'b0;
      run(1); check("t5_mid_data", state_dbg, DATA);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_grant", grant_idx, 0);
      check("t5_rst_state", state_dbg, IDLE);
      check("t5_rst_out", {m_valid_insert, m_valid_in, s_ready_insert, s_ready_in}, 0);
      check("t5_left", exp_d_q.size(), 2);
      exp_h_q.delete();
      exp_d_q.delete();
      clear_model();
      mr_in = 1'b1;
      run(1);
      rst_n = 1'b1;
      load(2, 1, 1, 4'hF); load(0, 1, 1, 4'hF);
      expect_pkt(0, 0, 1, 4'hF); expect_pkt(2, 0, 1, 4'hF);
      run(1); check("t5_idle", busy, 0);
      run(1); check("t5_grant0", grant_idx, 0);
      drain("t5_drain", 20);

      // Single-beat packet with keep 4'b1000 closes the grant; last_grant moves.
      load(1, 1, 1, 4'b1000);
      expect_pkt(1, 0, 1, 4'b1000);
      run(1);
      run(1); check("t6_grant1", grant_idx, 1);
      run(1); check("t6_data", state_dbg, DATA); check("t6_keep", m_keep_in, 4'b1000);
      check("t6_last", m_last_in, 1);
      run(1); check("t6_back_idle", state_dbg, IDLE);
      load(0, 1, 1, 4'hF); load(2, 1, 1, 4'hF);
      expect_pkt(2, 0, 1, 4'hF); expect_pkt(0, 0, 1, 4'hF);
      run(1); check("t6_idle", busy, 0);
      run(1); check("t6_grant2", grant_idx, 2);
      drain("t6_drain", 20);

      run(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_stream_header_arbiter.md
AXI_STREAM_HEADER_ARBITER -- requirements
Module: axi_stream_header_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WD, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, keep width.
REQ-003 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 s_valid_insert / s_ready_insert  input / output  N_REQ  per-requester header handshake.
REQ-008 s_header_insert / s_keep_insert  input  N_REQ*DATA_WD / N_REQ*DATA_BYTE_WD  packed headers and header keeps; requester i occupies slice i.
REQ-009 s_valid_in / s_ready_in / s_last_in  input / output / input  N_REQ  per-requester data handshake and last.
REQ-010 s_data_in / s_keep_in  input  N_REQ*DATA_WD / N_REQ*DATA_BYTE_WD  packed data and data keeps.
REQ-011 m_valid_insert, m_header_insert, m_keep_insert output; m_ready_insert input: header channel toward the header-insert datapath.
REQ-012 m_valid_in, m_data_in, m_keep_in, m_last_in output; m_ready_in input: data channel toward the datapath.
REQ-013 grant_idx  output  $clog2(N_REQ)  current owner; busy  output  1  high in HDR or DATA.

Function
REQ-014 The FSM SHALL have three states: IDLE, HDR and DATA.
REQ-015 In IDLE, if any s_valid_insert is high, the block SHALL register the winner into grant_idx and move to HDR on the next edge. Winner = first requester with s_valid_insert high, searching from last_grant+1 modulo N_REQ.
REQ-016 Arbitration SHALL consider s_valid_insert only; s_valid_in without a header SHALL never win.
REQ-017 In HDR, the m_*_insert outputs SHALL combinationally mirror the granted slice.
REQ-018 In HDR, s_ready_insert[grant_idx] SHALL equal m_ready_insert.
REQ-019 When m_valid_insert and m_ready_insert are both high, the FSM SHALL move to DATA.
REQ-020 In DATA, the m_*_in outputs SHALL combinationally mirror the granted slice, and s_ready_in[grant_idx] SHALL equal m_ready_in.
REQ-021 In DATA, a handshake with m_last_in high SHALL return the FSM to IDLE and load last_grant with grant_idx.
REQ-022 Grant SHALL be held for a whole packet; there is no preemption and no timeout.
REQ-023 Every non-granted s_ready_insert and s_ready_in bit SHALL be 0 at all times.
REQ-024 In IDLE, all m_valid_* and all s_ready_* SHALL be 0, giving a 1-cycle arbitration bubble between packets.
REQ-025 In HDR, m_valid_in SHALL be 0; in DATA, m_valid_insert SHALL be 0.
REQ-026 The mux path SHALL add zero latency: only the FSM state, grant_idx and last_grant are registered.
REQ-027 A requester that drops s_valid_insert in IDLE before being registered SHALL NOT be granted.
REQ-028 Once in HDR, the grant SHALL be kept regardless of what the requester does.
REQ-029 Single-beat packet: one DATA handshake with last SHALL end the grant.

Reset
REQ-030 Asserting rst_n low at any time, including mid-packet, SHALL immediately force IDLE, grant_idx=0, busy=0, last_grant=N_REQ-1, all m_valid_* = 0 and all s_ready_* = 0.
REQ-031 After reset, the first arbitration SHALL favour requester 0.
REQ-032 Registered m_* data fields do not exist, so no data reset value SHALL be required.

Structure
REQ-033 The state encoding enum (IDLE/HDR/DATA) SHALL live in the shared package axis_pkg.
REQ-034 The round-robin pick SHALL be a combinational sub-module, rr_arbiter (inputs req vector and last_grant; output grant index and any-request flag).

Verification
REQ-035 After reset, requesters 0 and 2 both assert s_valid_insert: grant_idx=0; header 0 then the 3-beat packet 0 appear on m_*; then grant_idx=2 after one IDLE cycle.
REQ-036 All 4 requesters continuously request, each sending 1-beat packets: grants SHALL rotate 0,1,2,3,0 with a bubble each time.
REQ-037 m_ready_in is toggled 1,0,1,0 during a 4-beat packet: every beat is delivered exactly once, the owner's s_ready_in tracks m_ready_in, and other s_ready_in stay 0.
REQ-038 Requester 1 asserts s_valid_in with no header while requester 3 has a header: grant_idx=3, and s_ready_in[1]=0 throughout.
REQ-039 rst_n is pulsed low in the middle of DATA of requester 2's packet: all valids and readies are 0 in the same cycle; after release, requesters 2 and 0 both pending produce grant 0.
REQ-040 A 1-beat packet with keep 4'b1000 SHALL return the FSM to IDLE on the handshake, and last_grant SHALL update.
